vga_rx_monitor: RTL and testbench

- VGA receiver/checker for the pixel stream our game top drives out (h_sync, v_sync, 4-bit R/G/B).
- Recovers pixel/line timing from the sync pulses, measures periods and pulse widths, and declares lock after consecutive conforming frames.
- While locked, captures the RGB value at a programmable probe coordinate.
- Used in simulation benches and as an on-board self-check tap beside the VGA pins.

---
 rtl/vga_rx_monitor_pkg.sv | 22 ++
 rtl/vga_rx_monitor_sync_edge_meter.sv | 37 +++
 rtl/vga_rx_monitor.sv | 166 ++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_monitor_pkg.sv
// Shared VGA timing defaults (640x480@60) and monitor FSM encoding, used by
// both the sync generator and the receive-side monitor.
package vga_rx_monitor_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BP        = 48;
    localparam int VGA_H_ACT       = 640;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BP        = 33;
    localparam int VGA_V_ACT       = 480;
    localparam int VGA_LOCK_FRAMES = 2;
    localparam int VGA_TIMEOUT     = 1600;

endpackage

// File: rtl/vga_rx_monitor_sync_edge_meter.sv
// Registers one active-low sync line, flags its edges and counts how long it
// stays low in units of count_en (clocks for h_sync, line starts for v_sync).
module vga_rx_monitor_sync_edge_meter #(
    parameter int W = 11
) (
    input  logic         clk_d,
    input  logic         reset,
    input  logic         sync,
    input  logic         count_en,
    output logic         fall,
    output logic         rise,
    output logic [W-1:0] width
);

    logic sync_q;
    logic sync_qq;

    assign fall = sync_qq & ~sync_q;
    assign rise = ~sync_qq & sync_q;

    // Idle level is high so leaving reset never fabricates an edge.
    always_ff @(posedge clk_d) begin
        if (reset) begin
            sync_q  <= 1'b1;
            sync_qq <= 1'b1;
            width   <= '0;
        end else begin
            sync_q  <= sync;
            sync_qq <= sync_q;
            if (fall)
                width <= count_en ? W'(1) : '0;
            else if (!sync_q && count_en && width != '1)
                width <= width + W'(1);
        end
    end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive-side checker: measures sync timing, locks after consecutive clean
// frames and captures the pixel at a programmable active-area coordinate.
module vga_rx_monitor
    import vga_rx_monitor_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int H_ACT       = VGA_H_ACT,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int V_ACT       = VGA_V_ACT,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES,
    parameter int TIMEOUT     = VGA_TIMEOUT
) (
    input  logic        clk_d,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    input  logic [9:0]  probe_x,
    input  logic [8:0]  probe_y,
    output logic        locked,
    output logic        frame_strobe,
    output logic [10:0] h_period,
    output logic [9:0]  v_lines,
    output logic [11:0] probe_rgb,
    output logic        probe_valid,
    output logic [7:0]  err_count
);

    localparam logic [10:0] X0 = 11'(H_SYNC + H_BP);
    localparam logic [9:0]  Y0 = 10'(V_SYNC + V_BP);

    logic        h_fall, h_rise, v_fall, v_rise;
    logic [10:0] h_width;
    logic [9:0]  v_width;
    logic [11:0] rgb_q;
    logic [10:0] hcnt, hcnt_nxt, tcnt;
    logic [9:0]  vcnt, vcnt_nxt;
    logic        err_latch, line_err, frame_ok, timeout, hit;
    logic [3:0]  good_cnt, good_nxt;
    logic        err_inc;
    mon_state_t  state, state_nxt;

    vga_rx_monitor_sync_edge_meter #(.W(11)) u_h_meter (
        .clk_d(clk_d), .reset(reset), .sync(h_sync), .count_en(1'b1),
        .fall(h_fall), .rise(h_rise), .width(h_width)
    );

    vga_rx_monitor_sync_edge_meter #(.W(10)) u_v_meter (
        .clk_d(clk_d), .reset(reset), .sync(v_sync), .count_en(h_fall),
        .fall(v_fall), .rise(v_rise), .width(v_width)
    );

    // Coordinates use the next-state counts: on any cycle they name the pixel
    // currently sitting in rgb_q, since both went through one register stage.
    always_comb begin
        hcnt_nxt = hcnt;
        if (h_fall)
            hcnt_nxt = '0;
        else if (hcnt != '1)
            hcnt_nxt = hcnt + 11'd1;
        vcnt_nxt = vcnt;
        if (v_fall)
            vcnt_nxt = '0;
        else if (h_fall && vcnt != '1)
            vcnt_nxt = vcnt + 10'd1;
    end

    assign line_err = (h_fall && (hcnt + 11'd1) != 11'(H_TOTAL))
                   || (h_rise && h_width != 11'(H_SYNC))
                   || (v_rise && v_width != 10'(V_SYNC));
    assign frame_ok = ((vcnt + 10'd1) == 10'(V_TOTAL)) && !err_latch && !line_err;
    assign timeout  = !h_fall && tcnt == 11'(TIMEOUT - 1);

    assign hit = hcnt_nxt >= X0 && hcnt_nxt < X0 + 11'(H_ACT)
              && vcnt_nxt >= Y0 && vcnt_nxt < Y0 + 10'(V_ACT)
              && (hcnt_nxt - X0) == {1'b0, probe_x}
              && (vcnt_nxt - Y0) == {1'b0, probe_y};

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_inc   = 1'b0;
        if (timeout) begin
            state_nxt = ST_SEARCH;
            good_nxt  = '0;
            err_inc   = (state == ST_LOCKED);
        end else if (v_fall) begin
            case (state)
                ST_SEARCH: begin
                    state_nxt = ST_MEASURE;
                    good_nxt  = '0;
                end
                ST_MEASURE: begin
                    if (frame_ok) begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 >= 4'(LOCK_FRAMES))
                            state_nxt = ST_LOCKED;
                    end else begin
                        good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_ok) begin
                        state_nxt = ST_MEASURE;
                        good_nxt  = '0;
                        err_inc   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_d) begin
        if (reset) begin
            state       <= ST_SEARCH;
            good_cnt    <= '0;
            rgb_q       <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            tcnt        <= '0;
            err_latch   <= 1'b0;
            h_period    <= '0;
            v_lines     <= '0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
            err_count   <= '0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            rgb_q     <= {red, green, blue};
            hcnt      <= hcnt_nxt;
            vcnt      <= vcnt_nxt;
            if (h_fall)
                tcnt <= '0;
            else if (tcnt != 11'(TIMEOUT))
                tcnt <= tcnt + 11'd1;
            err_latch <= v_fall ? 1'b0 : (err_latch | line_err);
            if (h_fall)
                h_period <= hcnt + 11'd1;
            if (v_fall)
                v_lines <= vcnt + 10'd1;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (state_nxt != ST_LOCKED)
                probe_valid <= 1'b0;
            else if (state == ST_LOCKED && hit) begin
                probe_rgb   <= rgb_q;
                probe_valid <= 1'b1;
            end
        end
    end

    assign locked       = (state == ST_LOCKED);
    assign frame_strobe = v_fall;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Frame-level directed bench for vga_rx_monitor using a shrunken raster so that
// many frames fit in a short run.
module tb_vga_rx_monitor;

    localparam int HT = 20, HS = 3, HB = 2, HA = 12;
    localparam int VT = 12, VS = 2, VB = 2, VA = 6;
    localparam int LF = 2, TO = 40;

    logic        clk_d = 1'b0;
    logic        reset, h_sync, v_sync;
    logic [3:0]  red, green, blue;
    logic [9:0]  probe_x;
    logic [8:0]  probe_y;
    logic        locked, frame_strobe, probe_valid;
    logic [10:0] h_period;
    logic [9:0]  v_lines;
    logic [11:0] probe_rgb;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;
    int cur   = -1;

    always #5 clk_d = ~clk_d;

    vga_rx_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA),
        .LOCK_FRAMES(LF), .TIMEOUT(TO)
    ) dut (
        .clk_d(clk_d), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue),
        .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .frame_strobe(frame_strobe),
        .h_period(h_period), .v_lines(v_lines),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid), .err_count(err_count)
    );

    // One frame to drive plus what must be visible just after its leading edge,
    // i.e. the verdict on the frame before it.
    typedef struct {
        int hsw;
        int vsl;
        int long_line;
        int px;
        int py;
        int lk_pre;
        int lk_post;
        int chk_meas;
        int pv;
        int err;
        int rgb;
    } vec_t;

    vec_t tbl[24];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (frame %0d): got 0x%0h expected 0x%0h", name, cur, act, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int l, input int c);
        if (l == VS + VB && c == HS + HB) return 12'h00F;
        if (l == VS + VB + VA - 1 && c == HS + HB + HA - 1) return 12'hF00;
        if (l >= VS + VB && l < VS + VB + VA && c >= HS + HB && c < HS + HB + HA)
            return 12'h0F0;
        return 12'h000;
    endfunction

    task automatic idle_inputs();
        h_sync = 1'b1;
        v_sync = 1'b1;
        {red, green, blue} = 12'h000;
    endtask

    task automatic drive_frame(input vec_t v, input int nlines, input bit do_chk);
        probe_x = 10'(v.px);
        probe_y = 9'(v.py);
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < HT + ((l == v.long_line) ? 1 : 0); c++) begin
                @(negedge clk_d);
                if (do_chk && l == 0 && c == 1) begin
                    check("frame_strobe", int'(frame_strobe), 1);
                    check("locked_before_edge", int'(locked), v.lk_pre);
                end
                if (do_chk && l == 0 && c == 4) begin
                    check("locked_after_edge", int'(locked), v.lk_post);
                    if (v.chk_meas != 0) begin
                        check("h_period", int'(h_period), HT);
                        check("v_lines", int'(v_lines), VT);
                    end
                    check("err_count", int'(err_count), v.err);
                    check("probe_valid", int'(probe_valid), v.pv);
                    check("probe_rgb", int'(probe_rgb), v.rgb);
                end
                {red, green, blue} = pix(l, c);
                h_sync = (c >= v.hsw);
                v_sync = (l >= v.vsl);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_frame_strobe"}, int'(frame_strobe), 0);
        check({tag, "_h_period"}, int'(h_period), 0);
        check({tag, "_v_lines"}, int'(v_lines), 0);
        check({tag, "_probe_rgb"}, int'(probe_rgb), 0);
        check({tag, "_probe_valid"}, int'(probe_valid), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        vec_t part;
        reset   = 1'b1;
        probe_x = '0;
        probe_y = '0;
        idle_inputs();

        //          hsw vsl long px  py  pre post meas pv err rgb
        tbl[0]  = '{3, 2, -1, 0,  0,  0, 0, 0, 0, 0, 'h000};
        tbl[1]  = '{3, 2, -1, 0,  0,  0, 0, 1, 0, 0, 'h000};
        tbl[2]  = '{3, 2, -1, 0,  0,  0, 1, 1, 0, 0, 'h000};
        tbl[3]  = '{3, 2, -1, 11, 5,  1, 1, 1, 1, 0, 'h00F};
        tbl[4]  = '{3, 2, 3,  5,  2,  1, 1, 1, 1, 0, 'hF00};
        tbl[5]  = '{3, 2, -1, 0,  0,  1, 0, 1, 0, 1, 'h0F0};
        tbl[6]  = '{3, 2, -1, 0,  0,  0, 0, 1, 0, 1, 'h0F0};
        tbl[7]  = '{3, 2, -1, 0,  0,  0, 1, 1, 0, 1, 'h0F0};
        tbl[8]  = '{3, 3, -1, 11, 5,  1, 1, 1, 1, 1, 'h00F};
        tbl[9]  = '{3, 3, -1, 0,  0,  1, 0, 1, 0, 2, 'hF00};
        tbl[10] = '{3, 3, -1, 0,  0,  0, 0, 1, 0, 2, 'hF00};
        tbl[11] = '{2, 2, -1, 0,  0,  0, 0, 1, 0, 2, 'hF00};
        tbl[12] = '{3, 2, -1, 0,  0,  0, 0, 1, 0, 2, 'hF00};
        tbl[13] = '{3, 2, -1, 0,  0,  0, 0, 1, 0, 2, 'hF00};
        tbl[14] = '{3, 2, -1, 12, 0,  0, 1, 1, 0, 2, 'hF00};
        tbl[15] = '{3, 2, -1, 5,  2,  1, 1, 1, 0, 2, 'hF00};
        tbl[16] = '{3, 2, -1, 0,  0,  0, 0, 0, 0, 3, 'h0F0};
        tbl[17] = '{3, 2, -1, 0,  0,  0, 0, 1, 0, 3, 'h0F0};
        tbl[18] = '{3, 2, -1, 0,  0,  0, 1, 1, 0, 3, 'h0F0};
        tbl[19] = '{3, 2, -1, 11, 5,  1, 1, 1, 1, 3, 'h00F};
        tbl[20] = '{3, 2, -1, 0,  0,  0, 0, 0, 0, 0, 'h000};
        tbl[21] = '{3, 2, -1, 0,  0,  0, 0, 1, 0, 0, 'h000};
        tbl[22] = '{3, 2, -1, 0,  0,  0, 1, 1, 0, 0, 'h000};
        tbl[23] = '{3, 2, -1, 0,  0,  1, 1, 1, 1, 0, 'h00F};

        repeat (3) @(negedge clk_d);
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cur = i;
            drive_frame(tbl[i], VT, 1'b1);
        end

        // Stop all sync activity while locked: lock must survive until the
        // watchdog expires, then drop with one error counted.
        cur = 100;
        idle_inputs();
        repeat (15) @(negedge clk_d);
        check("pre_timeout_locked", int'(locked), 1);
        check("pre_timeout_probe_valid", int'(probe_valid), 1);
        check("pre_timeout_probe_rgb", int'(probe_rgb), 'h0F0);
        repeat (15) @(negedge clk_d);
        check("timeout_locked", int'(locked), 0);
        check("timeout_probe_valid", int'(probe_valid), 0);
        check("timeout_err_count", int'(err_count), 3);

        for (int i = 16; i < 20; i++) begin
            cur = i;
            drive_frame(tbl[i], VT, 1'b1);
        end

        // Reset in the middle of a locked frame.
        cur = 200;
        part = tbl[19];
        drive_frame(part, 5, 1'b0);
        check("midframe_locked", int'(locked), 1);
        check("midframe_probe_valid", int'(probe_valid), 1);
        check("midframe_probe_rgb", int'(probe_rgb), 'hF00);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk_d);
        check_all_zero("midreset");
        @(negedge clk_d);
        reset = 1'b0;

        for (int i = 20; i < 24; i++) begin
            cur = i;
            drive_frame(tbl[i], VT, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
